digit_serial_addsub: RTL
========================

# digit_serial_addsub

Parametrised, clocked add/subtract unit that processes an N-bit operand pair D bits per cycle using a registered carry/borrow between digits. It generalises the team's combinational ripple subtractor into a multi-cycle datapath block with a start/done handshake, add/subtract mode selection and status flags. It sits beside the ALU datapath wherever area matters more than latency.

## Interface
- N, default 8: operand/result width in bits; N ≥ 2.
- D, default 2: digit width (bits processed per cycle); 1 ≤ D ≤ N, N % D == 0 (elaboration error otherwise).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low; the only reset.
- start  in  1  request; sampled only when busy == 0.
- mode  in  1  0 = add (a + b), 1 = subtract (a − b); latched with start.
- a  in  N  operand A; latched with start.
- b  in  N  operand B; latched with start.
- busy  out  1  high while a computation is in progress.
- done  out  1  single-cycle pulse; result and flags valid from this cycle.
- y  out  N  result, modulo 2^N.
- cout  out  1  add: carry out of bit N−1; subtract: borrow out (1 iff a < b unsigned).
- zero  out  1  y == 0.
- neg  out  1  y[N−1].
- ovf  out  1  two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 → latch a, b, mode; digit counter=0; carry/borrow register=0; go to RUN.
- RUN: busy=1. Each cycle processes digit k (bits k·D+D−1 … k·D) of latched operands, LSB digit first:
  - add: {c, digit} = a_k + b_k + c.
  - subtract: {bw, digit} = a_k − b_k − bw, borrow chain equivalent to cascaded full subtractors; no b-inversion / +1 trick required, but results must match.
  - carry/borrow register updated with the digit's out bit; digit stored into internal result shift register.
  - After digit N/D−1: y, cout, zero, neg, ovf registered from the completed result; go to DONE.
- DONE: done=1, busy=0, lasts one cycle. start=1 here is accepted exactly as in IDLE (back-to-back); otherwise → IDLE.
- start while busy=1: ignored, no effect on latched operands or sequence.
- Overflow: add: a[N−1]==b[N−1] and y[N−1]!=a[N−1]; subtract: a[N−1]!=b[N−1] and y[N−1]!=a[N−1].
- y and flags change only on the transition into DONE; held until next completion. Intermediate digits never appear on y.
- D == N: RUN lasts one cycle. D == 1: fully bit-serial.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE, busy=0, done=0, y=0, cout=0, zero=0, neg=0, ovf=0, counter and carry register 0.
- Reset mid-RUN: computation aborted, no done pulse, outputs return to reset values; after release next start behaves normally.
- start sampled at edge E0 → busy=1 from after E0 through E(N/D); done=1 and results valid after edge E(N/D); done low after E(N/D)+1.
- Latency start-edge to done = N/D cycles; throughput one operation per N/D+1 cycles (back-to-back start during DONE gives N/D+1 between done pulses).
- rst_n deassertion assumed synchronous to clk externally; no internal synchroniser.

## Test plan
- N=8,D=2, add a=0x7F b=0x01 → done exactly 4 cycles after start edge; y=0x80, cout=0, neg=1, ovf=1, zero=0; busy high 4 cycles.
- N=8,D=2, sub a=0x05 b=0x07 → y=0xFE, cout=1 (borrow), neg=1, ovf=0; sub a=0x80 b=0x01 → y=0x7F, cout=0, ovf=1; sub a=0x3C b=0x3C → y=0x00, zero=1, cout=0.
- Add a=0xFF b=0x01 → y=0x00, cout=1, zero=1, ovf=0; then start held high continuously → new operation accepted in DONE cycle, start pulses while busy ignored (operands changed mid-RUN do not affect result).
- Reset asserted at 2nd RUN cycle of sub 0x10−0x01 → outputs all 0 immediately, no done; after release, add 0x01+0x02 → y=0x03 in 4 cycles.
- Parameter sweep N=8 with D=1, 4, 8 and N=16,D=4: 1000 random a,b,mode vs. reference model (a±b mod 2^N, flags) → exact match; latency 8, 2, 1, 4 cycles respectively.

Source files
------------

// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract unit: an N-bit operand pair is processed D bits per
// cycle, LSB digit first, with a registered carry/borrow between digits.
module digit_serial_addsub #(
  parameter int N = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] y,
  output logic         cout,
  output logic         zero,
  output logic         neg,
  output logic         ovf
);
  localparam int NDIG = N / D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : gParamCheck
    $error("digit_serial_addsub: N must be >= 2 and a multiple of D, with 1 <= D <= N");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  opA_q, opA_d, opB_q, opB_d, acc_q, acc_d;
  logic          mode_q, mode_d, signA_q, signA_d, signB_q, signB_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] digitCnt_q, digitCnt_d;
  logic [N-1:0]  y_q, y_d;
  logic          cout_q, cout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

  logic [D:0]    digitSum;
  logic [N-1:0]  digitExt, accNext;
  logic          ovfNext;

  // One digit of the cascaded adder/subtractor; the top bit is carry or borrow.
  always_comb begin
    if (mode_q) begin
      digitSum = {1'b0, opA_q[D-1:0]} - {1'b0, opB_q[D-1:0]} - {{D{1'b0}}, carry_q};
    end else begin
      digitSum = {1'b0, opA_q[D-1:0]} + {1'b0, opB_q[D-1:0]} + {{D{1'b0}}, carry_q};
    end
    digitExt = N'(digitSum[D-1:0]);
    accNext  = (acc_q >> D) | (digitExt << (N - D));
    if (mode_q) begin
      ovfNext = (signA_q != signB_q) && (accNext[N-1] != signA_q);
    end else begin
      ovfNext = (signA_q == signB_q) && (accNext[N-1] != signA_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    acc_d      = acc_q;
    mode_d     = mode_q;
    signA_d    = signA_q;
    signB_d    = signB_q;
    carry_d    = carry_q;
    digitCnt_d = digitCnt_q;
    y_d        = y_q;
    cout_d     = cout_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          opA_d      = a;
          opB_d      = b;
          mode_d     = mode;
          signA_d    = a[N-1];
          signB_d    = b[N-1];
          carry_d    = 1'b0;
          digitCnt_d = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        opA_d   = opA_q >> D;
        opB_d   = opB_q >> D;
        acc_d   = accNext;
        carry_d = digitSum[D];
        // Results become visible only once the final digit has been folded in.
        if (digitCnt_q == CW'(NDIG - 1)) begin
          y_d     = accNext;
          cout_d  = digitSum[D];
          zero_d  = (accNext == '0);
          neg_d   = accNext[N-1];
          ovf_d   = ovfNext;
          state_d = DONE;
        end else begin
          digitCnt_d = digitCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      acc_q      <= '0;
      mode_q     <= 1'b0;
      signA_q    <= 1'b0;
      signB_q    <= 1'b0;
      carry_q    <= 1'b0;
      digitCnt_q <= '0;
      y_q        <= '0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      acc_q      <= acc_d;
      mode_q     <= mode_d;
      signA_q    <= signA_d;
      signB_q    <= signB_d;
      carry_q    <= carry_d;
      digitCnt_q <= digitCnt_d;
      y_q        <= y_d;
      cout_q     <= cout_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign y    = y_q;
  assign cout = cout_q;
  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
endmodule
